// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, FSM state type and defaults
// Purpose: common definitions imported by axi4_lite_master and axi4_lite_watchdog.
// Contents:
//   OKAY / EXOKAY / SLVERR / DECERR  2-bit xRESP codes
//   TIMEOUT_CYCLES_DEFAULT           default watchdog limit in aclk cycles
//   axi_state_e                      master FSM state encoding
package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam int TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } axi_state_e;

endpackage

// File: rtl/axi4_lite_watchdog.sv
// rtl/axi4_lite_watchdog.sv - busy-cycle counter with expire flag for the AXI4-Lite master
// Purpose: counts cycles spent waiting on the AXI slave and flags expiry.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   clear          restart the count (command accepted)
//   busy           master is waiting on an AXI channel this cycle
//   expired        count has reached TIMEOUT_CYCLES while busy
module axi4_lite_watchdog
  import axi4_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // The count saturates at the limit; expired is qualified with busy so the
  // flag is silent while the response sits in RSP holding a saturated count.
  assign expired = busy && (count == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (busy && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a local command port
// Purpose: converts one write/read command into AW/W/B or AR/R transfers and
//          returns the slave response on the local response port.
// Optional feature: define AXI4_LITE_MASTER_TIMEOUT_EN to enable the watchdog
//          that ends a stalled transaction after TIMEOUT_CYCLES with SLVERR.
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write,     command handshake and payload
//   cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot
//   rsp_valid/rsp_ready, rsp_rdata,     response handshake and payload
//   rsp_resp, rsp_timeout
//   aw*, w*, b*, ar*, r*                AXI4-Lite master channels
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_lite_master: TIMEOUT_CYCLES must be at least 1");
  end

  axi_state_e  state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  prot_q;
  logic        aw_done, w_done;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_resp_q;
  logic        timeout_q;

  logic accept;
  logic busy;
  logic expired;
  logic aw_hs, w_hs;

  assign busy = (state == WR) || (state == WR_RESP) ||
                (state == RD_ADDR) || (state == RD_DATA);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  axi4_lite_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (accept),
    .busy    (busy),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // cmd_ready is gated with aresetn so it reads 0 for the whole reset pulse,
  // not just from the first edge inside it.
  assign cmd_ready = aresetn && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Valids come straight from state and done flags, so the asynchronous
  // reset of the state register drops them immediately. On expiry they are
  // masked for the one cycle before RSP so no late handshake can slip in.
  assign awvalid   = (state == WR) && !aw_done && !expired;
  assign wvalid    = (state == WR) && !w_done && !expired;
  assign bready    = (state == WR_RESP) && !expired;
  assign arvalid   = (state == RD_ADDR) && !expired;
  assign rready    = (state == RD_DATA) && !expired;
  assign rsp_valid = (state == RSP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awprot  = prot_q;
  assign arprot  = prot_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = cmd_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (expired) begin
          state_next = RSP;
        end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (expired || bvalid) begin
          state_next = RSP;
        end
      end
      RD_ADDR: begin
        if (expired) begin
          state_next = RSP;
        end else if (arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (expired || rvalid) begin
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      timeout_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        prot_q    <= cmd_prot;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if (bready && bvalid) begin
        rsp_resp_q  <= bresp;
        rsp_rdata_q <= '0;
      end
      if (rready && rvalid) begin
        rsp_resp_q  <= rresp;
        rsp_rdata_q <= rdata;
      end
      if (busy && expired) begin
        rsp_resp_q  <= SLVERR;
        rsp_rdata_q <= '0;
        timeout_q   <= 1'b1;
      end
    end
  end

endmodule
